// File: rtl/rca_16bit.sv
// Ripple-carry adder built from a chain of one-bit full adders.
// The sum and carry-out are registered, giving one cycle of latency.
module rca_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH-1:0] sum_s;
    logic             carry_out_s;

    // One-bit full adder; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic k);
        logic sum_bit;
        logic carry_bit;
        sum_bit   = x ^ y ^ k;
        carry_bit = (x & y) | (x & k) | (y & k);
        return {carry_bit, sum_bit};
    endfunction

    // Ripple chain: each stage's carry-out feeds the next stage's carry-in.
    always_comb begin
        logic       k;
        logic [1:0] fa;
        sum_s       = {WIDTH{1'b0}};
        k           = c0;
        fa          = 2'b00;
        for (int i = 0; i < WIDTH; i++) begin
            fa       = full_add(a[i], b[i], k);
            sum_s[i] = fa[0];
            k        = fa[1];
        end
        carry_out_s = k;
    end

    // Output register; samples every cycle, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= {WIDTH{1'b0}};
            c <= 1'b0;
        end else begin
            s <= sum_s;
            c <= carry_out_s;
        end
    end

endmodule

// File: tb/tb_rca_16bit.sv
// Scoreboard bench for rca_16bit: a driver pushes expected results,
// a monitor pops and compares them against the registered outputs.
module tb_rca_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    logic [15:0] s;
    logic        c;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] s;
        logic        c;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    rca_16bit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c0    (c0),
        .s     (s),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer addition, split into sum and carry.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic k, input string name);
        exp_t e;
        int unsigned total;
        total  = int'(x) + int'(y) + int'(k);
        e.s    = total[15:0];
        e.c    = total[16];
        e.name = name;
        return e;
    endfunction

    task automatic check_direct(input string name, input logic [15:0] exp_s, input logic exp_c);
        checks++;
        if (s !== exp_s || c !== exp_c) begin
            errors++;
            $display("FAIL %s: got s=%h c=%b, expected s=%h c=%b", name, s, c, exp_s, exp_c);
        end
    endtask

    // Wait for the capturing edge and record what it should produce.
    task automatic capture(input string name);
        @(posedge clk);
        if (rst_n) exp_q.push_back(model(a, b, c0, name));
    endtask

    task automatic apply(input logic [15:0] x, input logic [15:0] y,
                         input logic k, input string name);
        @(negedge clk);
        #1;
        a  = x;
        b  = y;
        c0 = k;
        capture(name);
    endtask

    // Monitor: outputs are valid from each capturing edge; sample mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (s !== e.s || c !== e.c) begin
                errors++;
                $display("FAIL %s: got s=%h c=%b, expected s=%h c=%b", e.name, s, c, e.s, e.c);
            end
        end
    end

    initial begin
        int wait_cycles;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = 16'hFFFF;
        b      = 16'hFFFF;
        c0     = 1'b1;

        // Reset holds outputs at zero despite all-ones operands.
        #1;
        check_direct("reset_async", 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_direct("reset_hold", 16'h0000, 1'b0);
        end
        #2;
        rst_n = 1'b1;

        // Directed cases from the feature list.
        apply(16'h02EB, 16'h5555, 1'b0, "nominal");
        apply(16'hFFFF, 16'h0000, 1'b1, "full_ripple");
        apply(16'hFFFF, 16'hFFFF, 1'b1, "maximum");
        apply(16'h8000, 16'h8000, 1'b0, "msb_overflow");
        apply(16'h0001, 16'h0001, 1'b0, "b2b_0");
        apply(16'h1234, 16'h4321, 1'b1, "b2b_1");
        apply(16'h7FFF, 16'h0001, 1'b0, "b2b_2");

        // Mid-operation reset: capture 0x5840, then pulse reset between edges.
        apply(16'h02EB, 16'h5555, 1'b0, "pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_direct("midreset_async", 16'h0000, 1'b0);
        rst_n = 1'b1;
        a     = 16'h1111;
        b     = 16'h2222;
        c0    = 1'b1;
        #1;
        check_direct("midreset_released", 16'h0000, 1'b0);
        capture("post_reset");

        // Randomized back-to-back operands.
        for (int i = 0; i < 200; i++) begin
            apply(16'($urandom), 16'($urandom), 1'($urandom), "random");
        end
        apply(16'hFFFF, 16'h0001, 1'b0, "wrap_edge");

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results never compared, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_16bit.md
Name: rca_16bit

Overview:
- 16-bit ripple-carry adder with a registered result stage: s = a + b + c0, carry-out on c.
- Arithmetic core is a chain of WIDTH one-bit full adders. Bit i's carry-out is bit i+1's carry-in; there is no carry lookahead.
- Result and carry are captured in an output register, so downstream logic sees a stable, glitch-free sum one clock after the operands are presented.
- Used as the baseline adder against which faster adder variants in the design are compared.

Parameters:
- WIDTH, 16, operand and sum width in bits. The ripple chain length equals WIDTH; the block is verified at 16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c0  input  1  carry-in to bit 0.
- s  output  WIDTH  registered sum bits [WIDTH-1:0].
- c  output  1  registered carry-out of the MSB stage.

Behaviour:
- Full adder at bit i, with carry-in k(i) and k(0) = c0:
  - sum_i = a[i] ^ b[i] ^ k(i)
  - k(i+1) = (a[i] & b[i]) | (a[i] & k(i)) | (b[i] & k(i))
- Combinational result: {k(WIDTH), sum[WIDTH-1:0]}, which equals the full (WIDTH+1)-bit unsigned value a + b + c0. No truncation beyond WIDTH+1 bits.
- Register stage:
  - On each rising clk with rst_n high: s <= sum, c <= k(WIDTH).
  - There is no enable; the register samples every cycle.
- Latency: exactly 1 cycle. Operands stable before edge N produce s/c valid from edge N until the next edge.
- Reset:
  - rst_n low forces s = 0 and c = 0 immediately, without waiting for clk.
  - Outputs hold 0 while rst_n is low, whatever a/b/c0 are.
  - First capture is the first rising edge after rst_n deasserts.
  - Reset asserted mid-operation discards any captured result. No stale value reappears after release.
- Wrap-around: unsigned modulo 2^WIDTH on s, with the overflow bit reported on c. No signed-overflow flag is produced.
- Carry-in behaves as an ordinary addend bit. c0 = 1 with a = b = all-ones yields s = all-ones, c = 1 (the maximum result).
- Operands changing every cycle: each cycle's result depends only on that cycle's sampled inputs. There is no internal accumulation.
- Timing: the critical path is the full WIDTH-stage ripple from c0 or a[0]/b[0] to k(WIDTH). The register must close timing at the target clock with this chain.
- No X propagation is permitted from reset. All outputs are defined after the asynchronous reset.

Test Plan:
- Reset: hold rst_n = 0 with a = 0xFFFF, b = 0xFFFF, c0 = 1, and toggle clk → s = 0x0000, c = 0 throughout.
- Nominal: release reset; a = 0x02EB (16'b0000001011101011), b = 0x5555, c0 = 0; one clk edge → s = 0x5840 (16'b0101100001000000), c = 0.
- Full carry ripple: a = 0xFFFF, b = 0x0000, c0 = 1 → s = 0x0000, c = 1 one cycle later.
- Maximum: a = 0xFFFF, b = 0xFFFF, c0 = 1 → s = 0xFFFF, c = 1. MSB-only overflow: a = 0x8000, b = 0x8000, c0 = 0 → s = 0x0000, c = 1.
- Back-to-back operands:
  - Present on consecutive edges: (0x0001, 0x0001, 0) → then (0x1234, 0x4321, 1) → then (0x7FFF, 0x0001, 0).
  - Required results, each one cycle late: s = 0x0002, c = 0 → then s = 0x5556, c = 0 → then s = 0x8000, c = 0.
- Mid-operation reset: after a capture of s = 0x5840, pulse rst_n low between edges → s/c drop to 0 immediately. After release, the next edge captures the current operands only.
